// File: rtl/pipe_muldiv_ctrl.sv
// pipe_muldiv_ctrl
//   Iterative multiply/divide sequencer owning the HI/LO register pair.
//   Accepts mult/multu/div/divu from EX, runs 32 shift-add or restoring
//   divide iterations, then a sign-fix/commit cycle. Stalls ID while a
//   dependent HI/LO reader or another mult/div/mthi/mtlo is waiting.
// Ports:
//   clk, clrn            clock, synchronous active-high reset
//   estart, eop, ea, eb  EX mult/div request (eop: 00 mult, 01 multu,
//                        10 div, 11 divu), operands rs/rt
//   emthi, emtlo, ewdata EX mthi/mtlo write
//   dmfhi, dmflo, dmuldiv ID-stage hazard inputs
//   busy, stall, done    sequencer status
//   hi, lo               HI/LO registers
module pipe_muldiv_ctrl (
    input  logic        clk,
    input  logic        clrn,
    input  logic        estart,
    input  logic [1:0]  eop,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic        emthi,
    input  logic        emtlo,
    input  logic [31:0] ewdata,
    input  logic        dmfhi,
    input  logic        dmflo,
    input  logic        dmuldiv,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] ma;       // |multiplicand|
    logic [31:0] mb;       // |multiplier| (shifted) or |divisor|
    logic [31:0] araw;     // raw rs, returned in HI on divide-by-zero
    logic        isdiv;
    logic        sgn_q;    // product / quotient sign
    logic        sgn_r;    // remainder sign

    logic        op_signed;
    logic [31:0] abs_a, abs_b;
    logic [32:0] msum;
    logic [63:0] acc_mul, acc_div, prod;
    logic        div_ge;
    logic [31:0] quo, rem;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (estart) state_nx = RUN;
            RUN:     if (cnt == 5'd31) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (dmfhi | dmflo | dmuldiv);

    always_comb begin
        op_signed = ~eop[0];
        abs_a     = (op_signed && ea[31]) ? -ea : ea;
        abs_b     = (op_signed && eb[31]) ? -eb : eb;

        // Shift-add: add into the upper 33 bits, then shift the pair right.
        msum      = {1'b0, acc[63:32]} + (mb[0] ? {1'b0, ma} : 33'd0);
        acc_mul   = {msum, acc[31:1]};

        // Restoring divide: the shifted remainder is acc[63:31] (33 bits).
        // Subtracting in the full 64-bit pair is exact because the kept
        // result is always below 2^64.
        div_ge    = (acc[63:31] >= {1'b0, mb});
        acc_div   = div_ge ? ({acc[62:0], 1'b1} - {mb, 32'd0})
                           : {acc[62:0], 1'b0};

        prod      = sgn_q ? -acc : acc;
        quo       = sgn_q ? -acc[31:0] : acc[31:0];
        rem       = sgn_r ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            ma    <= '0;
            mb    <= '0;
            araw  <= '0;
            isdiv <= 1'b0;
            sgn_q <= 1'b0;
            sgn_r <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (estart) begin
                        isdiv <= eop[1];
                        ma    <= abs_a;
                        mb    <= abs_b;
                        araw  <= ea;
                        sgn_q <= op_signed & (ea[31] ^ eb[31]);
                        sgn_r <= op_signed & ea[31];
                        // Dividend sits in the quotient half so the left
                        // shifts feed it into the remainder bit by bit.
                        acc   <= eop[1] ? {32'd0, abs_a} : 64'd0;
                        cnt   <= '0;
                    end else begin
                        if (emthi) hi <= ewdata;
                        if (emtlo) lo <= ewdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (isdiv) begin
                        acc <= acc_div;
                    end else begin
                        acc <= acc_mul;
                        mb  <= mb >> 1;
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (isdiv) begin
                        if (mb == 32'd0) begin
                            hi <= araw;
                            lo <= '1;
                        end else begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end else begin
                        {hi, lo} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
module tb_pipe_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        clrn, estart, emthi, emtlo, dmfhi, dmflo, dmuldiv;
    logic [1:0]  eop;
    logic [31:0] ea, eb, ewdata;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;
    bit go     = 0;

    pipe_muldiv_ctrl dut (
        .clk(clk), .clrn(clrn), .estart(estart), .eop(eop), .ea(ea), .eb(eb),
        .emthi(emthi), .emtlo(emtlo), .ewdata(ewdata),
        .dmfhi(dmfhi), .dmflo(dmflo), .dmuldiv(dmuldiv),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    task automatic compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, sp, q, r;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        rh = '0;
        rl = '0;
        case (op)
            2'd0: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            2'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
            2'd2: begin
                if (b == 32'd0) begin rh = a; rl = 32'hFFFFFFFF; end
                else begin q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin rh = a; rl = 32'hFFFFFFFF; end
                else begin rh = a % b; rl = a / b; end
            end
        endcase
    endtask

    // Transaction-level model: cycles left busy, pending result, HI/LO.
    int          remaining = 0;
    logic [31:0] mhi = '0, mlo = '0, phi = '0, plo = '0;
    bit          mdone = 0;

    always @(posedge clk) begin
        if (clrn) begin
            remaining = 0; mhi = '0; mlo = '0; mdone = 0;
        end else begin
            mdone = 0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin mhi = phi; mlo = plo; mdone = 1; end
            end else if (estart) begin
                remaining = 33;
                compute(eop, ea, eb, phi, plo);
            end else begin
                if (emthi) mhi = ewdata;
                if (emtlo) mlo = ewdata;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("busy", {31'd0, busy}, {31'd0, remaining > 0});
            chk("done", {31'd0, done}, {31'd0, mdone});
            chk("stall", {31'd0, stall}, {31'd0, (remaining > 0) && (dmfhi || dmflo || dmuldiv)});
            chk("hi", hi, mhi);
            chk("lo", lo, mlo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mfhi, input bit poke, input string nm);
        int bc;
        estart = 1'b1; eop = op; ea = a; eb = b;
        step();
        estart = 1'b0; emthi = 1'b0; emtlo = 1'b0;
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            bc++;
            if (mfhi && k == 1) dmfhi = 1'b1;
            if (poke && k == 5) begin emthi = 1'b1; ewdata = 32'hDEADBEEF; end
            if (poke && k == 6) emthi = 1'b0;
            step();
        end
        chk({nm, "_busy_cycles"}, bc, 33);
        chk({nm, "_done_at_commit"}, {31'd0, done}, 32'd1);
        chk({nm, "_stall_released"}, {31'd0, stall}, 32'd0);
        dmfhi = 1'b0;
        step();
        chk({nm, "_done_cleared"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b1; estart = 1'b0; eop = 2'd0; ea = '0; eb = '0;
        emthi = 1'b0; emtlo = 1'b0; ewdata = '0;
        dmfhi = 1'b0; dmflo = 1'b0; dmuldiv = 1'b0;
        step(); step();
        go = 1;
        clrn = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        run_op(2'd0, 32'hFFFFFFFD, 32'd7, 0, 0, "mult");
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        chk("model_mult_lo", mlo, 32'hFFFFFFEB);

        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, "multu");
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0, "div");
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("model_div_hi", mhi, 32'hFFFFFFFF);

        run_op(2'd3, 32'h12345678, 32'd0, 0, 0, "divu0");
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h12345678);

        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, "divovf");
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h00000000);
        chk("model_divovf_lo", mlo, 32'h80000000);

        run_op(2'd3, 32'd100, 32'd7, 0, 0, "divu");
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        run_op(2'd2, 32'd7, 32'hFFFFFFFE, 0, 0, "div_negb");
        chk("div_negb_lo", lo, 32'hFFFFFFFD);
        chk("div_negb_hi", hi, 32'd1);

        // mfhi held in ID during a mult
        run_op(2'd0, 32'h00010000, 32'h00030000, 1, 0, "stall");
        chk("stall_hi", hi, 32'h00000003);
        chk("stall_lo", lo, 32'h00000000);

        emthi = 1'b1; ewdata = 32'hA5A5A5A5;
        step();
        emthi = 1'b0;
        chk("mthi", hi, 32'hA5A5A5A5);
        emthi = 1'b1; emtlo = 1'b1; ewdata = 32'h0F0F0F0F;
        step();
        emthi = 1'b0; emtlo = 1'b0;
        chk("mthi_both", hi, 32'h0F0F0F0F);
        chk("mtlo_both", lo, 32'h0F0F0F0F);

        // estart beats a simultaneous mtlo; mthi while busy is ignored
        emtlo = 1'b1; ewdata = 32'h11111111;
        run_op(2'd0, 32'd2, 32'd3, 0, 1, "mtlo_drop");
        chk("mtlo_drop_lo", lo, 32'd6);
        chk("mtlo_drop_hi", hi, 32'd0);

        // reset during RUN iteration 10
        estart = 1'b1; eop = 2'd1; ea = 32'd5; eb = 32'd9;
        step();
        estart = 1'b0;
        repeat (10) step();
        clrn = 1'b1;
        step();
        clrn = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        step();
        run_op(2'd1, 32'd5, 32'd9, 0, 0, "after_rst");
        chk("after_rst_lo", lo, 32'd45);
        chk("after_rst_hi", hi, 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
